// File: rtl/uart_register_pkg.sv
// -----------------------------------------------------------------------------
// uart_register_pkg
// Shared definitions for the UART register peripheral:
//   - register offsets relative to BASE_INDEX (DATA, STATUS)
//   - STATUS bit positions
//   - serial FSM state encoding shared by the TX and RX engines
//   - width of the per-frame data-bit counter
// -----------------------------------------------------------------------------
package uart_register_pkg;

    localparam int DATA_OFFSET   = 0;
    localparam int STATUS_OFFSET = 2;

    localparam int STAT_TX_NOT_FULL = 0;
    localparam int STAT_RX_VALID    = 1;
    localparam int STAT_RX_OVERRUN  = 2;
    localparam int STAT_TX_IDLE     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Eight data bits per frame -> counter 0..7.
    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/uart_register_peripheral_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used as the TX byte buffer.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset (empties the FIFO)
//   i_push, i_din  write request and data
//   i_pop          read request; o_dout shows the head entry (valid when !o_empty)
//   o_full/o_empty occupancy flags
//   o_count        number of stored entries, 0..DEPTH
// A push while full is only accepted when a pop happens on the same edge,
// so the count stays unchanged in that case. A pop while empty is ignored,
// so a push into an empty FIFO is never popped in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_register_peripheral.sv
// -----------------------------------------------------------------------------
// uart_register_peripheral
// Serial console on the core register bus. DATA writes are buffered in a TX
// FIFO and sent 8N1 on uart_tx; STATUS and received bytes are returned on
// register_read_value (registered, updated on the edge that samples
// register_read, held until the next read).
// Ports:
//   clk                   system clock
//   reset_n               synchronous active-low reset
//   register_index [6:0]  register address
//   register_read         one-cycle read strobe
//   register_write        one-cycle write strobe
//   register_write_value  write data, bits [7:0] used
//   register_read_value   registered read data
//   uart_tx               serial output, idle high
//   uart_rx               serial input (asynchronous)
// Optional receiver: define UART_RX_EN. Without it uart_rx is unused,
// STATUS bits 1..2 read 0 and DATA reads return 0.
// -----------------------------------------------------------------------------
module uart_register_peripheral
    import uart_register_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 4,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int BASE_INDEX    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int         CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int         FCW        = $clog2(TX_FIFO_DEPTH + 1);
    localparam logic [6:0] DATA_IDX   = 7'(BASE_INDEX + DATA_OFFSET);
    localparam logic [6:0] STATUS_IDX = 7'(BASE_INDEX + STATUS_OFFSET);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // ---------------- register decode ----------------
    logic w_data_wr;
    logic w_data_rd;
    logic w_status_rd;

    assign w_data_wr   = register_write && (register_index == DATA_IDX);
    assign w_data_rd   = register_read  && (register_index == DATA_IDX);
    assign w_status_rd = register_read  && (register_index == STATUS_IDX);

    // ---------------- TX FIFO ----------------
    logic [7:0]     w_fifo_dout;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [FCW-1:0] w_fifo_count;
    logic           w_tx_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_data_wr),
        .i_din   (register_write_value[7:0]),
        .i_pop   (w_tx_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ---------------- TX engine ----------------
    uart_state_t          r_tx_state;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [BIT_CNT_W-1:0] r_tx_bit;
    logic [7:0]           r_tx_shift;
    logic                 r_tx;
    logic                 w_tx_idle;

    // Load the next byte from IDLE, or straight out of the last stop-bit
    // clock so consecutive frames have no idle gap.
    assign w_tx_pop  = !w_fifo_empty &&
                       ((r_tx_state == IDLE) ||
                        ((r_tx_state == STOP) && (r_tx_cnt == BIT_LAST)));
    assign w_tx_idle = w_fifo_empty && (r_tx_state == IDLE);
    assign uart_tx   = r_tx;

    // uart_tx is registered from the current state, so the line trails the
    // state by one clock; every bit still lasts CLKS_PER_BIT clocks. This
    // gives the start bit 2 clocks after the write edge (push, then pop).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                IDLE: begin
                    r_tx     <= 1'b1;
                    r_tx_cnt <= '0;
                    if (w_tx_pop) begin
                        r_tx_shift <= w_fifo_dout;
                        r_tx_state <= START;
                    end
                end
                START: begin
                    r_tx <= 1'b0;
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    r_tx <= r_tx_shift[0];
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        if (r_tx_bit == BIT_CNT_W'(7)) begin
                            r_tx_state <= STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + BIT_CNT_W'(1);
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (w_tx_pop) begin
                            r_tx_shift <= w_fifo_dout;
                            r_tx_state <= START;
                        end else begin
                            r_tx_state <= IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_tx_state <= IDLE;
                end
            endcase
        end
    end

    // ---------------- RX engine (optional) ----------------
    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_overrun;

`ifdef UART_RX_EN
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_prev;
    uart_state_t          r_rx_state;
    logic [CNT_W-1:0]     r_rx_cnt;
    logic [BIT_CNT_W-1:0] r_rx_bit;
    logic [7:0]           r_rx_shift;
    logic [7:0]           r_rx_byte;
    logic                 r_rx_valid;
    logic                 r_rx_overrun;
    logic                 w_rx_load;

    // A good stop bit (line high at mid-stop) commits the byte.
    assign w_rx_load = (r_rx_state == STOP) && (r_rx_cnt == BIT_LAST) && r_rx_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            case (r_rx_state)
                IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= START;
                    end
                end
                START: begin
                    // Re-check half a bit in; a high line was a glitch.
                    if (r_rx_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? IDLE : DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == BIT_CNT_W'(7)) begin
                            r_rx_state <= STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + BIT_CNT_W'(1);
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_rx_state <= IDLE;
                end
            endcase
        end
    end

    // A DATA read on the load edge returns the old byte (register_read_value
    // samples r_rx_byte before it updates) and leaves the new byte valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_rx_load) begin
                r_rx_byte <= r_rx_shift;
            end
            if (w_rx_load) begin
                r_rx_valid <= 1'b1;
            end else if (w_data_rd) begin
                r_rx_valid <= 1'b0;
            end
            if (w_data_rd) begin
                r_rx_overrun <= 1'b0;
            end else if (w_rx_load && r_rx_valid) begin
                r_rx_overrun <= 1'b1;
            end
        end
    end

    assign w_rx_byte    = r_rx_byte;
    assign w_rx_valid   = r_rx_valid;
    assign w_rx_overrun = r_rx_overrun;
`else
    logic w_rx_unused;

    assign w_rx_byte    = 8'h00;
    assign w_rx_valid   = 1'b0;
    assign w_rx_overrun = 1'b0;
    assign w_rx_unused  = uart_rx;
`endif

    // ---------------- read data ----------------
    logic [15:0] w_status;
    logic [15:0] r_read_value;
    logic        w_unused;

    always_comb begin
        w_status                   = 16'h0000;
        w_status[STAT_TX_NOT_FULL] = !w_fifo_full;
        w_status[STAT_RX_VALID]    = w_rx_valid;
        w_status[STAT_RX_OVERRUN]  = w_rx_overrun;
        w_status[STAT_TX_IDLE]     = w_tx_idle;
    end

    assign w_unused            = ^{register_write_value[15:8], w_fifo_count};
    assign register_read_value = r_read_value;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_read_value <= 16'h0000;
        end else if (register_read) begin
            if (w_data_rd) begin
                r_read_value <= {8'h00, w_rx_byte};
            end else if (w_status_rd) begin
                r_read_value <= w_status;
            end else begin
                r_read_value <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_uart_register_peripheral.sv
// -----------------------------------------------------------------------------
// tb_uart_register_peripheral
// Directed bench for uart_register_peripheral. Expected TX frames are queued
// when DATA is written and checked by a line monitor as frames complete.
// RX checks are built when UART_RX_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_register_peripheral;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic        uart_tx;
    logic        uart_rx;

    uart_register_peripheral #(
        .CLKS_PER_BIT  (CPB),
        .TX_FIFO_DEPTH (DEPTH),
        .BASE_INDEX    (0)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .uart_tx              (uart_tx),
        .uart_rx              (uart_rx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;   // expected start cycle, or -1 = contiguous with previous frame
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   mon_en   = 1'b1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [6:0] idx, input logic [15:0] val, output int c);
        @(negedge clk);
        register_index       = idx;
        register_write_value = val;
        register_write       = 1'b1;
        @(negedge clk);
        register_write = 1'b0;
        c = cyc;
    endtask

    task automatic reg_read(input logic [6:0] idx, output logic [15:0] val);
        @(negedge clk);
        register_index = idx;
        register_read  = 1'b1;
        @(negedge clk);
        register_read = 1'b0;
        val = register_read_value;
        $display("read  idx=%0d -> %h", idx, val);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        check("tx_drain", 16'(exp_q.size()), 16'h0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic watch_idle(input string tag, input int n);
        int lows;
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check(tag, 16'(lows), 16'h0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // Line monitor: decodes 8N1 frames at bit centres and compares with the queue.
    initial begin
        int         s;
        int         last_s;
        logic       start_bit;
        logic       stop_bit;
        logic [7:0] got;
        exp_t       e;
        last_s = 0;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n === 1'b1 && uart_tx === 1'b0) begin
                s = cyc;
                repeat (CPB / 2) @(negedge clk);
                start_bit = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = uart_tx;
                repeat (CPB - CPB / 2 - 1) @(negedge clk);
                $display("frame start=%0d data=%h stop=%b", s, got, stop_bit);
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fails++;
                    $error("FAIL tx_unexpected_frame: observed %h required none", got);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_start_bit", 16'(start_bit), 16'h0);
                    check("tx_data", 16'(got), 16'(e.data));
                    check("tx_stop_bit", 16'(stop_bit), 16'h1);
                    if (e.start >= 0) check("tx_start_time", 16'(s), 16'(e.start));
                    else              check("tx_contiguous", 16'(s), 16'(last_s + 10 * CPB));
                end
                last_s = s;
            end
        end
    end

    initial begin
        logic [15:0] v;
        int          c;
        exp_t        e;

        reset_n              = 1'b0;
        register_index       = '0;
        register_read        = 1'b0;
        register_write       = 1'b0;
        register_write_value = '0;
        uart_rx              = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_uart_tx", 16'(uart_tx), 16'h1);
        check("reset_read_value", register_read_value, 16'h0000);
        reset_n = 1'b1;

        // STATUS at idle, and hold until the next read
        reg_read(7'd2, v);
        check("status_idle", v, 16'h0009);
        repeat (5) @(negedge clk);
        check("read_value_hold", register_read_value, 16'h0009);

        // Single byte 0x41: start bit 2 clocks after the write edge
        reg_write(7'd0, 16'h0041, c);
        e.data = 8'h41; e.start = c + 2; exp_q.push_back(e);
        $display("write data=41 at cyc=%0d", c);
        wait_drain(20 * CPB);
        reg_read(7'd2, v);
        check("status_after_0x41", v, 16'h0009);

        // Burst of 10 bytes: shifter takes 0x30, FIFO holds 0x31..0x38, 0x39 is dropped
        e.data = 8'h30; e.start = -1; exp_q.push_back(e);
        for (int i = 1; i < 9; i++) begin
            e.data = 8'(8'h30 + i); e.start = -1; exp_q.push_back(e);
        end
        @(negedge clk);
        register_index = 7'd0;
        register_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            register_write_value = 16'(16'h0030 + i);
            @(negedge clk);
            if (i == 0) c = cyc;
            $display("write data=%h (burst)", 8'(8'h30 + i));
        end
        register_write = 1'b0;
        exp_q[0].start = c + 2;
        reg_read(7'd2, v);
        check("status_full_busy", v, 16'h0000);
        wait_drain(12 * 10 * CPB);
        watch_idle("no_dropped_byte", 12 * CPB);
        reg_read(7'd2, v);
        check("status_after_burst", v, 16'h0009);

        // Unmapped index 5
        reg_write(7'd5, 16'h0055, c);
        reg_read(7'd5, v);
        check("read_index5", v, 16'h0000);
        watch_idle("tx_quiet_index5", 12 * CPB);

`ifdef UART_RX_EN
        send_rx(8'h5A);
        repeat (4) @(negedge clk);
        reg_read(7'd2, v);
        check("status_rx_valid", v, 16'h000B);
        reg_read(7'd0, v);
        check("rx_data_5a", v, 16'h005A);
        reg_read(7'd2, v);
        check("status_rx_cleared", v, 16'h0009);
        send_rx(8'hA5);
        send_rx(8'h3C);
        repeat (4) @(negedge clk);
        reg_read(7'd2, v);
        check("status_rx_overrun", v, 16'h000F);
        reg_read(7'd0, v);
        check("rx_data_second", v, 16'h003C);
        reg_read(7'd2, v);
        check("status_overrun_cleared", v, 16'h0009);
`else
        send_rx(8'h5A);
        repeat (4) @(negedge clk);
        reg_read(7'd0, v);
        check("rx_disabled_data", v, 16'h0000);
        reg_read(7'd2, v);
        check("rx_disabled_status", v, 16'h0009);
`endif

        // Reset in the middle of a data bit, with a second byte still queued
        mon_en = 1'b0;
        @(negedge clk);
        register_index       = 7'd0;
        register_write_value = 16'h0000;
        register_write       = 1'b1;
        @(negedge clk);
        c = cyc;
        @(negedge clk);
        register_write = 1'b0;
        $display("write data=00 x2 at cyc=%0d (reset abort)", c);
        while (cyc < c + 2 + CPB + CPB + CPB / 2) @(negedge clk);
        check("tx_low_before_reset", 16'(uart_tx), 16'h0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("tx_high_after_reset", 16'(uart_tx), 16'h1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        reg_read(7'd2, v);
        check("status_after_reset", v, 16'h0009);
        watch_idle("fifo_discarded", 15 * CPB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
